note_sequencer: RTL and testbench

- Plays a melody by stepping through a sequence memory and drives the half-period (hp) and active inputs of the square-wave frequency synthesiser.
- Each memory entry gives a pitch, a duration in beats and flags (rest, end); beat timing comes from an internal clk prescaler.
- Inserts a short articulation gap at the end of every note; supports one-shot and looped playback, with start/stop control from the top level.

---
 rtl/note_sequencer_pkg.sv | 28 ++
 rtl/note_sequencer_if.sv | 35 +++
 rtl/note_sequencer_beat_timer.sv | 62 ++++++
 rtl/note_sequencer.sv | 135 +++++++++++++
 tb/tb_note_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg
// Shared definitions for the note sequencer: sequence-entry field positions,
// FSM state encoding and the beat count used when an entry's duration is 0.
package note_sequencer_pkg;

  localparam int unsigned ENTRY_W  = 13;
  localparam int unsigned END_BIT  = 12;
  localparam int unsigned REST_BIT = 11;
  localparam int unsigned DUR_MSB  = 10;
  localparam int unsigned DUR_LSB  = 7;
  localparam int unsigned HP_MSB   = 6;

  localparam logic [4:0] DUR_ZERO_BEATS = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  // Duration field to beat count; a zero field stands for the longest note.
  function automatic logic [4:0] entry_beats(input logic [3:0] dur);
    return (dur == 4'd0) ? DUR_ZERO_BEATS : {1'b0, dur};
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if
// Bundles the sequencer's control, sequence-memory and synthesiser signals.
//   start/stop/loop : playback control (into sequencer)
//   mem_addr/mem_rd : sequence memory read request (from sequencer)
//   mem_data        : entry returned the cycle after mem_rd (into sequencer)
//   hp/active       : synthesiser half-period and gate (from sequencer)
//   busy/done       : status (from sequencer)
// master = sequencer side, slave = environment side.
interface note_sequencer_if #(
  parameter int unsigned ADDR_W = 6
);
  import note_sequencer_pkg::*;

  logic                start;
  logic                stop;
  logic                loop;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd;
  logic [ENTRY_W-1:0]  mem_data;
  logic [6:0]          hp;
  logic                active;
  logic                busy;
  logic                done;

  modport master (
    input  start, stop, loop, mem_data,
    output mem_addr, mem_rd, hp, active, busy, done
  );

  modport slave (
    output start, stop, loop, mem_data,
    input  mem_addr, mem_rd, hp, active, busy, done
  );

endinterface

// File: rtl/note_sequencer_beat_timer.sv
// note_sequencer_beat_timer
// Prescaler (BEAT_DIV clk cycles per beat) plus a beat down-counter.
//   clk, rst       : clock, async active-high reset
//   load_i         : restart prescaler at 0 and load beats_i
//   run_i          : advance the timer this cycle
//   beats_i        : beat count to load (1..16)
//   last_beat_o    : currently in the final beat
//   in_gap_o       : current cycle lies in the final GAP_CYCLES of the note
//   gap_enter_o    : current cycle is the one just before the gap
//   beat_wrap_o    : current cycle is the last cycle of a beat
module note_sequencer_beat_timer #(
  parameter logic [23:0] BEAT_DIV   = 24'd1_000_000,
  parameter logic [23:0] GAP_CYCLES = 24'd50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       run_i,
  input  logic [4:0] beats_i,
  output logic       last_beat_o,
  output logic       in_gap_o,
  output logic       gap_enter_o,
  output logic       beat_wrap_o
);

  localparam logic [23:0] GAP_START = BEAT_DIV - GAP_CYCLES;

  logic [23:0] presc_q, presc_d;
  logic [4:0]  beats_q, beats_d;

  assign beat_wrap_o = (presc_q == BEAT_DIV - 24'd1);
  assign last_beat_o = (beats_q == 5'd1);
  assign in_gap_o    = last_beat_o && (presc_q >= GAP_START);
  assign gap_enter_o = last_beat_o && (presc_q == GAP_START - 24'd1);

  always_comb begin
    presc_d = presc_q;
    beats_d = beats_q;
    if (load_i) begin
      presc_d = '0;
      beats_d = beats_i;
    end else if (run_i) begin
      if (beat_wrap_o) begin
        presc_d = '0;
        beats_d = beats_q - 5'd1;
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      beats_q <= '0;
    end else begin
      presc_q <= presc_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
// Steps through a sequence memory and drives a square-wave synthesiser.
// Each entry {end, rest, dur, hp} plays for dur beats (0 = 16); the final
// GAP_CYCLES of every note are silent. Supports one-shot and looped play.
//   clk, rst : clock, async active-high reset
//   bus      : note_sequencer_if.master (control, memory, synth, status)
// All outputs are registered.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter logic [23:0] BEAT_DIV   = 24'd1_000_000,
  parameter logic [23:0] GAP_CYCLES = 24'd50_000
) (
  input  logic clk,
  input  logic rst,
  note_sequencer_if.master bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [6:0]          hp_q, hp_d;
  logic                active_q, active_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                snd_q, snd_d;

  logic       e_end, e_rest, e_sounds;
  logic [3:0] e_dur;
  logic [6:0] e_hp;

  logic tm_load, tm_run;
  logic last_beat, in_gap, gap_enter, beat_wrap, note_end;

  assign e_end    = bus.mem_data[END_BIT];
  assign e_rest   = bus.mem_data[REST_BIT];
  assign e_dur    = bus.mem_data[DUR_MSB:DUR_LSB];
  assign e_hp     = bus.mem_data[HP_MSB:0];
  assign e_sounds = !e_rest && (e_hp != '0);

  assign tm_load  = (state_q == S_LATCH) && !e_end;
  assign tm_run   = (state_q == S_PLAY) || (state_q == S_GAP);
  assign note_end = last_beat && beat_wrap;

  note_sequencer_beat_timer #(
    .BEAT_DIV   (BEAT_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_beat_timer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (tm_load),
    .run_i       (tm_run),
    .beats_i     (entry_beats(e_dur)),
    .last_beat_o (last_beat),
    .in_gap_o    (in_gap),
    .gap_enter_o (gap_enter),
    .beat_wrap_o (beat_wrap)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state; stop overrides everything, including start in IDLE
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (bus.start) state_d = S_FETCH;
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          if (e_end) state_d = bus.loop ? S_FETCH : S_IDLE;
          else       state_d = S_PLAY;
        end
        S_PLAY:  if (gap_enter || in_gap) state_d = S_GAP;
        S_GAP:   if (note_end) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output next-values are derived from state_d so the registered outputs
  // line up with the state they belong to, without a combinational path.
  always_comb begin
    addr_d = addr_q;
    hp_d   = hp_q;
    snd_d  = snd_q;
    if (state_q == S_LATCH) snd_d = e_sounds;
    if (state_d == S_FETCH) begin
      unique case (state_q)
        S_IDLE, S_LATCH: addr_d = '0;
        S_GAP:           addr_d = addr_q + ADDR_W'(1);
        default:         addr_d = addr_q;
      endcase
    end
    if ((state_q == S_LATCH) && (state_d == S_PLAY) && e_sounds) hp_d = e_hp;
    rd_d     = (state_d == S_FETCH);
    active_d = (state_d == S_PLAY) && snd_d;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_LATCH) && e_end && !bus.loop && !bus.stop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      rd_q     <= 1'b0;
      hp_q     <= 7'd1;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      snd_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      hp_q     <= hp_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      snd_q    <= snd_d;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_rd   = rd_q;
  assign bus.hp       = hp_q;
  assign bus.active   = active_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
// Scoreboard bench: stimulus pushes expected events (memory reads, sounded
// notes with their length, done pulses); a monitor turns DUT activity into
// the same events and compares them in order.
module tb_note_sequencer;

  localparam logic [23:0] BD = 24'd8;
  localparam logic [23:0] GC = 24'd2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_sequencer_if #(.ADDR_W(6)) if1 ();
  note_sequencer_if #(.ADDR_W(2)) if2 ();

  note_sequencer #(.ADDR_W(6), .BEAT_DIV(BD), .GAP_CYCLES(GC)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.master)
  );
  note_sequencer #(.ADDR_W(2), .BEAT_DIV(BD), .GAP_CYCLES(GC)) dut2 (
    .clk (clk), .rst (rst), .bus (if2.master)
  );

  logic [12:0] mem1 [64];
  logic [12:0] mem2 [4];

  always @(posedge clk) if (if1.mem_rd) if1.mem_data <= mem1[if1.mem_addr];
  always @(posedge clk) if (if2.mem_rd) if2.mem_data <= mem2[if2.mem_addr];

  // Monitor source select: 0 = dut1, 1 = dut2
  logic       sel;
  logic       m_rd, m_act, m_busy, m_done;
  logic [5:0] m_addr;
  logic [6:0] m_hp;
  always_comb begin
    if (sel) begin
      m_rd = if2.mem_rd; m_act = if2.active; m_busy = if2.busy; m_done = if2.done;
      m_addr = {4'b0, if2.mem_addr}; m_hp = if2.hp;
    end else begin
      m_rd = if1.mem_rd; m_act = if1.active; m_busy = if1.busy; m_done = if1.done;
      m_addr = if1.mem_addr; m_hp = if1.hp;
    end
  end

  typedef enum int {EV_RD, EV_NOTE, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e k;
    int       a;
    int       b;
    int       c;
  } ev_t;
  ev_t sbq[$];

  int errors = 0;
  int checks = 0;

  function automatic logic [12:0] ent(input bit e, input bit r, input int dur, input int hp);
    logic [3:0] d;
    logic [6:0] h;
    d = dur[3:0];
    h = hp[6:0];
    return {e, r, d, h};
  endfunction

  task automatic expect_ev(input ev_kind_e k, input int a, input int b, input int c);
    ev_t e;
    e.k = k; e.a = a; e.b = b; e.c = c;
    sbq.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input int a, input int b, input int c);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got a=%0d b=%0d c=%0d, expected no event", k.name(), a, b, c);
    end else begin
      e = sbq.pop_front();
      if (e.k != k || e.a != a || e.b != b || e.c != c) begin
        errors++;
        $display("FAIL event_%s: got %s a=%0d b=%0d c=%0d, expected %s a=%0d b=%0d c=%0d",
                 e.k.name(), k.name(), a, b, c, e.k.name(), e.a, e.b, e.c);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: RD a=addr b=cycles since previous read in this busy period;
  // NOTE a=hp b=active-high cycles c=cycles from read to active rising.
  initial begin
    int  since_rd = 0;
    int  run_len  = 0;
    int  run_hp   = 0;
    int  rise_del = 0;
    bit  have_rd  = 0;
    bit  prev_act = 0;
    forever begin
      @(negedge clk);
      since_rd++;
      if (!m_busy) have_rd = 0;
      if (m_act && !prev_act) begin
        run_len = 1; run_hp = m_hp; rise_del = since_rd;
      end else if (m_act) begin
        run_len++;
      end
      if (!m_act && prev_act) observe(EV_NOTE, run_hp, run_len, rise_del);
      prev_act = m_act;
      if (m_rd) begin
        observe(EV_RD, m_addr, have_rd ? since_rd : 0, 0);
        since_rd = 0;
        have_rd  = 1;
      end
      if (m_done) observe(EV_DONE, 0, 0, 0);
    end
  end

  task automatic wait_drain(input string name, input int maxcyc);
    int n = 0;
    while (sbq.size() != 0 && n < maxcyc) begin
      @(negedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: %0d events pending, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic pulse_start(input bit which);
    if (which) if2.start = 1'b1; else if1.start = 1'b1;
    @(negedge clk); #1;
    if2.start = 1'b0;
    if1.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    if1.start = 1'b0; if1.stop = 1'b0; if1.loop = 1'b0;
    if2.start = 1'b0; if2.stop = 1'b0; if2.loop = 1'b0;
    for (int i = 0; i < 64; i++) mem1[i] = ent(1, 0, 0, 0);
    for (int i = 0; i < 4; i++)  mem2[i] = ent(1, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_hp",     if1.hp, 1);
    check("rst_active", if1.active, 0);
    check("rst_busy",   if1.busy, 0);
    check("rst_done",   if1.done, 0);
    check("rst_rd",     if1.mem_rd, 0);
    check("rst_addr",   if1.mem_addr, 0);
    check("rst_hp2",    if2.hp, 1);

    // One note of 2 beats then end; a start while busy must be ignored
    mem1[0] = ent(0, 0, 2, 20);
    mem1[1] = ent(1, 0, 0, 0);
    expect_ev(EV_RD, 0, 0, 0);
    expect_ev(EV_NOTE, 20, 14, 2);
    expect_ev(EV_RD, 1, 18, 0);
    expect_ev(EV_DONE, 0, 0, 0);
    pulse_start(0);
    repeat (6) @(negedge clk);
    #1;
    pulse_start(0);
    wait_drain("oneshot", 100);
    check("oneshot_busy", if1.busy, 0);

    // Rest entry keeps previous hp and stays silent
    mem1[0] = ent(0, 0, 1, 20);
    mem1[1] = ent(0, 1, 1, 33);
    mem1[2] = ent(1, 0, 0, 0);
    expect_ev(EV_RD, 0, 0, 0);
    expect_ev(EV_NOTE, 20, 6, 2);
    expect_ev(EV_RD, 1, 10, 0);
    expect_ev(EV_RD, 2, 10, 0);
    expect_ev(EV_DONE, 0, 0, 0);
    pulse_start(0);
    wait_drain("rest", 100);
    check("rest_hp_hold", if1.hp, 20);

    // Duration 0 plays 16 beats
    mem1[0] = ent(0, 0, 0, 5);
    mem1[1] = ent(1, 0, 0, 0);
    expect_ev(EV_RD, 0, 0, 0);
    expect_ev(EV_NOTE, 5, 126, 2);
    expect_ev(EV_RD, 1, 130, 0);
    expect_ev(EV_DONE, 0, 0, 0);
    pulse_start(0);
    wait_drain("dur16", 300);

    // Looped playback, then stop
    mem1[0] = ent(0, 0, 1, 10);
    mem1[1] = ent(0, 0, 1, 11);
    mem1[2] = ent(1, 0, 0, 0);
    if1.loop = 1'b1;
    for (int p = 0; p < 2; p++) begin
      expect_ev(EV_RD, 0, (p == 0) ? 0 : 2, 0);
      expect_ev(EV_NOTE, 10, 6, 2);
      expect_ev(EV_RD, 1, 10, 0);
      expect_ev(EV_NOTE, 11, 6, 2);
      expect_ev(EV_RD, 2, 10, 0);
    end
    expect_ev(EV_RD, 0, 2, 0);
    pulse_start(0);
    wait_drain("loop", 200);
    check("loop_busy", if1.busy, 1);
    check("loop_addr", if1.mem_addr, 0);
    if1.stop = 1'b1;
    @(negedge clk); #1;
    if1.stop = 1'b0;
    if1.loop = 1'b0;
    check("loop_stop_busy", if1.busy, 0);

    // Stop mid-play on note 2, then restart from address 0
    mem1[0] = ent(0, 0, 1, 10);
    mem1[1] = ent(0, 0, 2, 12);
    mem1[2] = ent(1, 0, 0, 0);
    expect_ev(EV_RD, 0, 0, 0);
    expect_ev(EV_NOTE, 10, 6, 2);
    expect_ev(EV_RD, 1, 10, 0);
    pulse_start(0);
    wait_drain("stop_pre", 100);
    expect_ev(EV_NOTE, 12, 5, 2);
    repeat (6) @(negedge clk);
    if1.stop = 1'b1;
    @(negedge clk); #1;
    if1.stop = 1'b0;
    check("stop_active", if1.active, 0);
    check("stop_busy",   if1.busy, 0);
    check("stop_done",   if1.done, 0);
    check("stop_hp",     if1.hp, 12);
    wait_drain("stop_note", 5);
    repeat (3) @(negedge clk);
    #1;
    expect_ev(EV_RD, 0, 0, 0);
    expect_ev(EV_NOTE, 10, 6, 2);
    expect_ev(EV_RD, 1, 10, 0);
    expect_ev(EV_NOTE, 12, 14, 2);
    expect_ev(EV_RD, 2, 18, 0);
    expect_ev(EV_DONE, 0, 0, 0);
    pulse_start(0);
    wait_drain("restart", 150);

    // stop beats start in IDLE
    if1.start = 1'b1;
    if1.stop  = 1'b1;
    @(negedge clk); #1;
    if1.start = 1'b0;
    if1.stop  = 1'b0;
    check("prio_busy", if1.busy, 0);
    repeat (3) @(negedge clk);
    #1;
    check("prio_busy_later", if1.busy, 0);

    // ADDR_W=2 wrap, then async reset mid-note
    sel = 1'b1;
    for (int i = 0; i < 4; i++) mem2[i] = ent(0, 0, 1, 40 + i);
    expect_ev(EV_RD, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      expect_ev(EV_NOTE, 40 + i, 6, 2);
      expect_ev(EV_RD, (i + 1) % 4, 10, 0);
    end
    pulse_start(1);
    wait_drain("wrap", 200);
    expect_ev(EV_NOTE, 40, 3, 2);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_hp",     if2.hp, 1);
    check("arst_active", if2.active, 0);
    check("arst_busy",   if2.busy, 0);
    check("arst_addr",   if2.mem_addr, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    wait_drain("arst_note", 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
